// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter that drains a synchronous FIFO
// (one-cycle read latency) into a valid/ready stream. A 2-entry buffer
// plus a credit check on issued reads keeps the stream at full rate
// without overflowing the buffer or losing/duplicating words.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      rd_count,
  output logic                  busy
);

  // Two-entry holding buffer with 1-bit ring pointers.
  logic [FIFO_WIDTH-1:0] r_buf [2];
  logic                  r_rptr;
  logic                  r_wptr;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_rd_count;

  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_occ_next;
  logic                  w_rd_en;

  // Handshake, occupancy projection and read-credit decision. The projected
  // occupancy counts the word already in flight and credits a pop happening
  // this cycle, so reads restart in the same cycle backpressure releases.
  always_comb begin
    w_valid    = (r_occ != 2'd0);
    w_pop      = w_valid & m_ready;
    w_occ_next = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd_en    = ~rst & enable & ~fifo_empty & (w_occ_next < 3'd2);
  end

  // Buffer contents: capture the FIFO word one cycle after its read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wptr   <= 1'b0;
    end else if (r_inflight) begin
      r_buf[r_wptr] <= fifo_dout;
      r_wptr        <= ~r_wptr;
    end
  end

  // Control state: read pointer, occupancy, in-flight flag, delivery count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_rd_count <= '0;
    end else begin
      if (w_pop) begin
        r_rptr     <= ~r_rptr;
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
      r_occ      <= w_occ_next[1:0];
      r_inflight <= w_rd_en;
    end
  end

  // Outputs come straight from registered state (except the read strobe).
  always_comb begin
    fifo_rd_en = w_rd_en;
    m_valid    = w_valid;
    m_data     = r_buf[r_rptr];
    rd_count   = r_rd_count;
    busy       = w_valid | r_inflight;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + random-stall bench for fifo_rd_stream with a behavioural
// depth-8 FIFO model (one-cycle read latency) and an in-order scoreboard.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic [15:0] rd_count;
  logic        busy;

  logic        fifo_rd_en4;
  logic        m_valid4;
  logic [15:0] m_data4;
  logic [3:0]  rd_count4;
  logic        busy4;

  logic [15:0] f_mem [8];
  logic [2:0]  f_wp;
  logic [2:0]  f_rp;
  logic [3:0]  f_cnt;

  logic [15:0] exp_q [$];
  int          hs = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count), .busy(busy)
  );

  // Narrow-counter instance on the same inputs; behaves identically except rd_count.
  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4),
    .m_data(m_data4), .m_ready(m_ready), .rd_count(rd_count4), .busy(busy4)
  );

  // Behavioural FIFO: write and read on the rising edge, data the cycle after rd_en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp      <= '0;
      f_rp      <= '0;
      f_cnt     <= '0;
      fifo_dout <= '0;
    end else begin
      if (wr_en) begin
        f_mem[f_wp] <= wr_data;
        f_wp        <= f_wp + 3'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= f_mem[f_rp];
        f_rp      <= f_rp + 3'd1;
      end
      f_cnt <= f_cnt + 4'(wr_en) - 4'(fifo_rd_en);
    end
  end
  assign fifo_empty = (f_cnt == 4'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must deliver the next word written to the FIFO.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_word", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        if (m_valid4) chk("sb4_data", 32'(m_data4), 32'(exp_q[0]));
        chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst     = 1'b1;
    wr_en   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    hs = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Power-on reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) push(16'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("str_first_rd", 32'(fifo_rd_en), 32'd1);
    tick();
    chk("str_lat_valid", 32'(m_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("str_valid", 32'(m_valid), 32'd1);
      chk("str_data", 32'(m_data), 32'(k));
    end
    tick();
    chk("str_count", 32'(rd_count), 32'd8);
    chk("str_busy", 32'(busy), 32'd0);
    chk("str_valid_end", 32'(m_valid), 32'd0);

    // Asynchronous reset with a full buffer
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'hC000 + 16'(i));
    enable = 1'b1;
    repeat (4) tick();
    chk("mid_valid", 32'(m_valid), 32'd1);
    chk("mid_data", 32'(m_data), 32'hC001);
    chk("mid_fifo_left", 32'(f_cnt), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    hs = 0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("arst_count", 32'(rd_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_data", 32'(m_data), 32'd0);
    m_ready = 1'b1;
    push(16'h7777);
    repeat (3) tick();
    chk("post_rst_count", 32'(rd_count), 32'd1);

    // Backpressure: three words, m_ready low
    do_reset();
    push(16'hA5A5);
    push(16'h5A5A);
    push(16'h1234);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n += int'(fifo_rd_en);
      tick();
    end
    chk("bp_reads", 32'(n), 32'd2);
    chk("bp_fifo_left", 32'(f_cnt), 32'd1);
    chk("bp_rd_stop", 32'(fifo_rd_en), 32'd0);
    chk("bp_head", 32'(m_data), 32'hA5A5);
    m_ready = 1'b1;
    #1;
    chk("bp_resume_rd", 32'(fifo_rd_en), 32'd1);
    tick();
    chk("bp_w2_valid", 32'(m_valid), 32'd1);
    chk("bp_w2", 32'(m_data), 32'h5A5A);
    tick();
    chk("bp_w3_valid", 32'(m_valid), 32'd1);
    chk("bp_w3", 32'(m_data), 32'h1234);
    tick();
    chk("bp_done_valid", 32'(m_valid), 32'd0);
    chk("bp_done_busy", 32'(busy), 32'd0);

    // Enable drop right after a read strobe
    do_reset();
    push(16'h0BB1);
    push(16'h0BB2);
    enable  = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("en_rd", 32'(fifo_rd_en), 32'd1);
    tick();
    enable = 1'b0;
    #1;
    chk("en_off_rd", 32'(fifo_rd_en), 32'd0);
    chk("en_off_busy", 32'(busy), 32'd1);
    tick();
    chk("en_inflight_valid", 32'(m_valid), 32'd1);
    chk("en_inflight_data", 32'(m_data), 32'h0BB1);
    tick();
    chk("en_idle_valid", 32'(m_valid), 32'd0);
    chk("en_idle_rd", 32'(fifo_rd_en), 32'd0);
    chk("en_fifo_left", 32'(f_cnt), 32'd1);
    enable = 1'b1;
    #1;
    chk("en_resume_rd", 32'(fifo_rd_en), 32'd1);
    tick();
    tick();
    chk("en_resume_data", 32'(m_data), 32'h0BB2);
    tick();
    chk("en_end_busy", 32'(busy), 32'd0);

    // Random stalls and random writes
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (f_cnt < 4'd8 && $urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = 16'($urandom);
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en   = 1'b0;
    m_ready = 1'b1;
    repeat (20) tick();
    chk("rand_leftover", 32'(exp_q.size()), 32'd0);
    chk("rand_count", 32'(rd_count), 32'(hs[15:0]));
    chk("rand_busy", 32'(busy), 32'd0);

    // Counter wrap on the 4-bit instance
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
    repeat (4) tick();
    chk("wrap_hs", 32'(hs), 32'd17);
    chk("wrap_count4", 32'(rd_count4), 32'd1);
    chk("wrap_count16", 32'(rd_count), 32'd17);
    chk("wrap_busy4", 32'(busy4), 32'd0);
    chk("wrap_rd_en4", 32'(fifo_rd_en4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
